disparity_vga: RTL



---
 rtl/disparity_vga.sv | 130 +++++++++++++
 1 files changed

// File: rtl/disparity_vga.sv
// VGA raster generator that displays a disparity image in a window at the visible origin.
// Two-stage pipeline: stage 0 addresses the image, stage 1 scales the returned index to RRRGGGBB.
module disparity_vga #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned IMG_W     = 450,
   parameter int unsigned IMG_H     = 375,
   parameter int unsigned GAIN      = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_ce,
   input  logic       disp_valid,
   input  logic [7:0] new_image,
   output logic [9:0] disp_href,
   output logic [9:0] disp_vref,
   output logic       hsync,
   output logic       vsync,
   output logic [7:0] vga_rgb,
   output logic       frame_start
);

   localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] HLast       = 10'(HTotal - 1);
   localparam logic [9:0] VLast       = 10'(VTotal - 1);
   localparam logic [9:0] HVis        = 10'(H_VISIBLE);
   localparam logic [9:0] VVis        = 10'(V_VISIBLE);
   localparam logic [9:0] ImgW        = 10'(IMG_W);
   localparam logic [9:0] ImgH        = 10'(IMG_H);
   localparam logic [9:0] HSyncStart  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HSyncEnd    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VSyncStart  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VSyncEnd    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [15:0] Gain16     = 16'(GAIN);

   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic       frame_ok_q;

   // Stage 0 registers
   logic       in_win_q, visible_q, hsync0_q, vsync0_q;
   logic [9:0] href_q, vref_q;

   // Stage 1 registers
   logic       hsync_q, vsync_q;
   logic [7:0] rgb_q, rgb_d;

   logic        at_origin;
   logic        in_win_d, visible_d, hsync_raw, vsync_raw;
   logic [15:0] prod;
   logic [7:0]  scaled;

   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (hcnt_q == HLast) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 10'd1;
      end else begin
         hcnt_d = hcnt_q + 10'd1;
      end
   end

   always_comb begin
      at_origin = (hcnt_q == '0) && (vcnt_q == '0);
      in_win_d  = (hcnt_q < ImgW) && (vcnt_q < ImgH);
      visible_d = (hcnt_q < HVis) && (vcnt_q < VVis);
      hsync_raw = !((hcnt_q >= HSyncStart) && (hcnt_q <= HSyncEnd));
      vsync_raw = !((vcnt_q >= VSyncStart) && (vcnt_q <= VSyncEnd));
   end

   // new_image belongs to the pixel currently held in stage 0
   always_comb begin
      prod   = 16'(new_image) * Gain16;
      scaled = (prod[15:8] != 8'd0) ? 8'hFF : prod[7:0];
      rgb_d  = 8'h00;
      if (visible_q && in_win_q) begin
         rgb_d = frame_ok_q ? {scaled[7:5], scaled[7:5], scaled[7:6]} : 8'h03;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         frame_ok_q <= 1'b0;
         in_win_q   <= 1'b0;
         visible_q  <= 1'b0;
         hsync0_q   <= 1'b1;
         vsync0_q   <= 1'b1;
         href_q     <= '0;
         vref_q     <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         rgb_q      <= '0;
      end else if (pix_ce) begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         // Sampled once per frame so a frame never mixes dark-blue fill and data
         if (at_origin) begin
            frame_ok_q <= disp_valid;
         end
         in_win_q  <= in_win_d;
         visible_q <= visible_d;
         hsync0_q  <= hsync_raw;
         vsync0_q  <= vsync_raw;
         href_q    <= in_win_d ? hcnt_q : '0;
         vref_q    <= in_win_d ? vcnt_q : '0;
         hsync_q   <= hsync0_q;
         vsync_q   <= vsync0_q;
         rgb_q     <= rgb_d;
      end
   end

   assign disp_href   = href_q;
   assign disp_vref   = vref_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign vga_rgb     = rgb_q;
   assign frame_start = pix_ce && at_origin && !reset;

endmodule
